simon_datapath: RTL and testbench

//  Datapath partner of the Simon control FSM. It consumes the FSM's control

---
 rtl/simon_datapath.sv | 84 ++++++++
 tb/tb_simon_datapath.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/simon_datapath.sv
// Simon datapath: pattern memory, sequence-length and playback counters, LED mux.
// Latency: status flags are combinational; state advances on step-qualified clk edges; no backpressure.
module simon_datapath #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic [WIDTH-1:0] pattern,
    input  logic             m1,
    input  logic             m2,
    input  logic             m3,
    input  logic             m4,
    input  logic             count_ns,
    input  logic             count_i,
    input  logic             rst_i,
    input  logic             reset,
    output logic             legal,
    output logic             i_eq_ns,
    output logic             right_guess,
    output logic             full,
    output logic [WIDTH-1:0] pattern_leds
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    ns_cnt_q, ns_cnt_d;
    logic [AW-1:0]    i_cnt_q, i_cnt_d;
    logic [WIDTH-1:0] mem_rd;

    assign mem_rd      = mem_q[i_cnt_q];
    assign full        = (ns_cnt_q == LAST);
    assign legal       = ($countones(pattern) == 1) && !full;
    assign i_eq_ns     = (i_cnt_q == ns_cnt_q);
    assign right_guess = (pattern == mem_rd);

    always_comb begin
        ns_cnt_d = ns_cnt_q;
        i_cnt_d  = i_cnt_q;
        if (step) begin
            if (count_ns && !full) begin
                ns_cnt_d = ns_cnt_q + AW'(1);
            end
            if (rst_i) begin
                i_cnt_d = '0;
            end else if (count_i) begin
                i_cnt_d = i_cnt_q + AW'(1);
            end
        end
    end

    // Either reset source clears the counters even when no step is pending.
    always_ff @(posedge clk) begin
        if (rst || reset) begin
            ns_cnt_q <= '0;
            i_cnt_q  <= '0;
        end else begin
            ns_cnt_q <= ns_cnt_d;
            i_cnt_q  <= i_cnt_d;
        end
    end

    // Write address is the pre-increment ns_cnt; legal already blocks writes when full.
    always_ff @(posedge clk) begin
        if (step && m1 && legal) begin
            mem_q[ns_cnt_q] <= pattern;
        end
    end

    always_comb begin
        pattern_leds = '0;
        if (m1) begin
            pattern_leds = pattern;
        end else if (m2) begin
            pattern_leds = mem_rd;
        end else if (m3) begin
            pattern_leds = pattern;
        end else if (m4) begin
            pattern_leds = mem_rd;
        end
    end
endmodule

// File: tb/tb_simon_datapath.sv
// Directed bench for simon_datapath; a DEPTH=4 instance shares the inputs to reach the full condition.
module tb_simon_datapath;
    logic       clk = 1'b0;
    logic       rst, step, m1, m2, m3, m4, count_ns, count_i, rst_i, reset;
    logic [3:0] pattern;
    logic       legal, i_eq_ns, right_guess, full;
    logic [3:0] pattern_leds;
    logic       legal4, i_eq_ns4, right_guess4, full4;
    logic [3:0] pattern_leds4;
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 clk = ~clk;

    simon_datapath #(.WIDTH(4), .DEPTH(64)) dut (
        .clk(clk), .rst(rst), .step(step), .pattern(pattern),
        .m1(m1), .m2(m2), .m3(m3), .m4(m4),
        .count_ns(count_ns), .count_i(count_i), .rst_i(rst_i), .reset(reset),
        .legal(legal), .i_eq_ns(i_eq_ns), .right_guess(right_guess),
        .full(full), .pattern_leds(pattern_leds)
    );

    simon_datapath #(.WIDTH(4), .DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .step(step), .pattern(pattern),
        .m1(m1), .m2(m2), .m3(m3), .m4(m4),
        .count_ns(count_ns), .count_i(count_i), .rst_i(rst_i), .reset(reset),
        .legal(legal4), .i_eq_ns(i_eq_ns4), .right_guess(right_guess4),
        .full(full4), .pattern_leds(pattern_leds4)
    );

    task automatic clear_strobes();
        m1 = 0; m2 = 0; m3 = 0; m4 = 0;
        count_ns = 0; count_i = 0; rst_i = 0; reset = 0; step = 0;
    endtask

    // Entered and left at a negedge; step is high across exactly one posedge.
    task automatic pulse_step();
        step = 1;
        @(negedge clk);
        step = 0;
        #1;
    endtask

    task automatic do_rst();
        rst = 1;
        @(negedge clk);
        rst = 0;
        #1;
    endtask

    task automatic test_reset();
        clear_strobes();
        pattern = 4'b0000;
        do_rst();
        n_tests++; if (i_eq_ns !== 1'b1) begin n_fail++; $display("FAIL rst_i_eq_ns got %b want 1", i_eq_ns); end
        n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL rst_full got %b want 0", full); end
        n_tests++; if (pattern_leds !== 4'b0000) begin n_fail++; $display("FAIL rst_leds got %b want 0000", pattern_leds); end
        pattern = 4'b0100; #1;
        n_tests++; if (legal !== 1'b1) begin n_fail++; $display("FAIL legal_0100 got %b want 1", legal); end
        pattern = 4'b0000; #1;
        n_tests++; if (legal !== 1'b0) begin n_fail++; $display("FAIL legal_0000 got %b want 0", legal); end
        pattern = 4'b0110; #1;
        n_tests++; if (legal !== 1'b0) begin n_fail++; $display("FAIL legal_0110 got %b want 0", legal); end
        pattern = 4'b1111; #1;
        n_tests++; if (legal !== 1'b0) begin n_fail++; $display("FAIL legal_1111 got %b want 0", legal); end
        @(negedge clk);
    endtask

    task automatic test_write_read();
        clear_strobes();
        m1 = 1; pattern = 4'b0010;
        pulse_step();
        m1 = 0; m2 = 1; pattern = 4'b1000; #1;
        n_tests++; if (pattern_leds !== 4'b0010) begin n_fail++; $display("FAIL m2_leds got %b want 0010", pattern_leds); end
        m1 = 1; #1;
        n_tests++; if (pattern_leds !== 4'b1000) begin n_fail++; $display("FAIL m1_priority got %b want 1000", pattern_leds); end
        m1 = 0; m2 = 0; m3 = 1; pattern = 4'b0010; #1;
        n_tests++; if (right_guess !== 1'b1) begin n_fail++; $display("FAIL guess_right got %b want 1", right_guess); end
        n_tests++; if (pattern_leds !== 4'b0010) begin n_fail++; $display("FAIL m3_leds got %b want 0010", pattern_leds); end
        pattern = 4'b0100; #1;
        n_tests++; if (right_guess !== 1'b0) begin n_fail++; $display("FAIL guess_wrong got %b want 0", right_guess); end
        m3 = 0; m4 = 1; #1;
        n_tests++; if (pattern_leds !== 4'b0010) begin n_fail++; $display("FAIL m4_leds got %b want 0010", pattern_leds); end
        @(negedge clk);
    endtask

    task automatic test_sequence();
        logic [3:0] seq [3];
        seq[0] = 4'b0001; seq[1] = 4'b1000; seq[2] = 4'b0010;
        clear_strobes();
        do_rst();
        @(negedge clk);
        // Last entry written without count_ns, leaving ns_cnt at 2.
        for (int k = 0; k < 3; k++) begin
            m1 = 1; pattern = seq[k]; count_ns = (k < 2);
            pulse_step();
        end
        clear_strobes();
        m2 = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_tests++; if (pattern_leds !== seq[k]) begin n_fail++; $display("FAIL play_leds[%0d] got %b want %b", k, pattern_leds, seq[k]); end
            n_tests++; if (i_eq_ns !== (k == 2)) begin n_fail++; $display("FAIL play_i_eq_ns[%0d] got %b want %b", k, i_eq_ns, (k == 2)); end
            if (k < 2) begin count_i = 1; pulse_step(); count_i = 0; end
        end
    endtask

    task automatic test_hold();
        clear_strobes();
        m1 = 1; pattern = 4'b0001; count_i = 1; count_ns = 1;
        #1;
        n_tests++; if (legal !== 1'b1) begin n_fail++; $display("FAIL hold_legal got %b want 1", legal); end
        repeat (10) @(negedge clk);
        clear_strobes();
        m2 = 1; #1;
        n_tests++; if (pattern_leds !== 4'b0010) begin n_fail++; $display("FAIL hold_mem got %b want 0010", pattern_leds); end
        n_tests++; if (i_eq_ns !== 1'b1) begin n_fail++; $display("FAIL hold_cnt got %b want 1", i_eq_ns); end
    endtask

    task automatic test_clear();
        clear_strobes();
        m2 = 1; rst_i = 1; count_i = 1;
        pulse_step();
        rst_i = 0; count_i = 0;
        n_tests++; if (pattern_leds !== 4'b0001) begin n_fail++; $display("FAIL rst_i_leds got %b want 0001", pattern_leds); end
        n_tests++; if (i_eq_ns !== 1'b0) begin n_fail++; $display("FAIL rst_i_eq got %b want 0", i_eq_ns); end
        count_ns = 1;
        repeat (3) pulse_step();
        count_ns = 0; count_i = 1;
        repeat (5) pulse_step();
        count_i = 0;
        n_tests++; if (i_eq_ns !== 1'b1) begin n_fail++; $display("FAIL ns5_eq got %b want 1", i_eq_ns); end
        rst_i = 1; pulse_step(); rst_i = 0;
        count_i = 1; pulse_step(); count_i = 0;
        n_tests++; if (pattern_leds !== 4'b1000) begin n_fail++; $display("FAIL i1_leds got %b want 1000", pattern_leds); end
        reset = 1;
        @(negedge clk);
        reset = 0; #1;
        n_tests++; if (i_eq_ns !== 1'b1) begin n_fail++; $display("FAIL reset_eq got %b want 1", i_eq_ns); end
        n_tests++; if (pattern_leds !== 4'b0001) begin n_fail++; $display("FAIL reset_leds got %b want 0001", pattern_leds); end
    endtask

    task automatic test_full();
        logic [3:0] seq [3];
        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100;
        clear_strobes();
        do_rst();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            m1 = 1; count_ns = 1; pattern = seq[k];
            n_tests++; if (full4 !== 1'b0) begin n_fail++; $display("FAIL pre_full[%0d] got %b want 0", k, full4); end
            pulse_step();
        end
        pattern = 4'b1000; #1;
        n_tests++; if (full4 !== 1'b1) begin n_fail++; $display("FAIL full_set got %b want 1", full4); end
        n_tests++; if (legal4 !== 1'b0) begin n_fail++; $display("FAIL full_legal got %b want 0", legal4); end
        pulse_step();
        n_tests++; if (full4 !== 1'b1) begin n_fail++; $display("FAIL full_sat got %b want 1", full4); end
        clear_strobes();
        m2 = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_tests++; if (pattern_leds4 !== seq[k]) begin n_fail++; $display("FAIL full_mem[%0d] got %b want %b", k, pattern_leds4, seq[k]); end
            count_i = 1; pulse_step(); count_i = 0;
        end
        n_tests++; if (i_eq_ns4 !== 1'b1) begin n_fail++; $display("FAIL full_ns3 got %b want 1", i_eq_ns4); end
        n_tests++; if (pattern_leds4 === 4'b1000) begin n_fail++; $display("FAIL full_nowrite got %b want not 1000", pattern_leds4); end
    endtask

    initial begin
        rst = 0;
        pattern = 4'b0000;
        clear_strobes();
        test_reset();
        test_write_read();
        test_sequence();
        test_hold();
        test_clear();
        test_full();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
